// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-stage load/store sequencer between the pipeline and a simple
//   request/acknowledge data bus. A legal access stalls the pipeline,
//   issues one registered bus request, waits for dmem_ack, formats load
//   data into ReadDataM, then releases the pipeline for exactly one cycle.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   MemReadM, MemWriteM   memory-stage load / store
//   Funct3M               access size and signedness
//   ALUResultM            effective byte address
//   WriteDataM            low-aligned store data
//   dmem_req/we/addr/wdata/be   registered bus request
//   dmem_ack, dmem_rdata  bus completion and read word
//   ReadDataM             registered, formatted load result
//   StallM                freeze memory stage and upstream
//   MisalignedM           illegal or misaligned access (combinational)
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignedM
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  // Access attributes captured at request time; dmem_addr drops the
  // low address bits, so the byte offset is kept separately.
  logic [2:0]  lat_f3;
  logic [1:0]  lat_off;
  logic        lat_load;

  logic        valid, both, funct_ok, align_ok, legal;
  logic        start, stall;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_fmt;

  // Legality decode
  always_comb begin
    valid    = MemReadM ^ MemWriteM;
    both     = MemReadM & MemWriteM;
    funct_ok = 1'b0;
    if (MemReadM) begin
      case (Funct3M)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funct_ok = 1'b1;
        default:                                funct_ok = 1'b0;
      endcase
    end else if (MemWriteM) begin
      case (Funct3M)
        3'b000, 3'b001, 3'b010: funct_ok = 1'b1;
        default:                funct_ok = 1'b0;
      endcase
    end
    case (Funct3M[1:0])
      2'b01:   align_ok = ~ALUResultM[0];
      2'b10:   align_ok = (ALUResultM[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    legal = valid & funct_ok & align_ok;
  end

  // Store lane replication and byte enables
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = WriteDataM;
    case (Funct3M[1:0])
      2'b00: begin
        be_new    = 4'b0001 << ALUResultM[1:0];
        wdata_new = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be_new    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{WriteDataM[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = WriteDataM;
      end
    endcase
  end

  // Load lane select and extension
  always_comb begin
    case (lat_off)
      2'd0:    lane_b = dmem_rdata[7:0];
      2'd1:    lane_b = dmem_rdata[15:8];
      2'd2:    lane_b = dmem_rdata[23:16];
      default: lane_b = dmem_rdata[31:24];
    endcase
    lane_h = lat_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (lat_f3)
      3'b000:  load_fmt = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_fmt = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_fmt = {24'd0, lane_b};
      3'b101:  load_fmt = {16'd0, lane_h};
      default: load_fmt = dmem_rdata;
    endcase
  end

  // Next-state and control
  always_comb begin
    next_state  = state;
    start       = 1'b0;
    stall       = 1'b0;
    MisalignedM = 1'b0;
    case (state)
      IDLE: begin
        if (legal) begin
          start      = 1'b1;
          stall      = 1'b1;
          next_state = BUSY;
        end else if (valid | both) begin
          MisalignedM = 1'b1;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (dmem_ack) next_state = DONE;
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Stall is combinational from state and inputs, so it is gated by reset
  // to stay low while rst_n is held, even with a legal access presented.
  assign StallM = stall & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      ReadDataM  <= '0;
      lat_f3     <= '0;
      lat_off    <= '0;
      lat_load   <= 1'b0;
    end else if (start) begin
      dmem_req   <= 1'b1;
      dmem_we    <= MemWriteM;
      dmem_addr  <= {ALUResultM[31:2], 2'b00};
      dmem_wdata <= wdata_new;
      dmem_be    <= be_new;
      lat_f3     <= Funct3M;
      lat_off    <= ALUResultM[1:0];
      lat_load   <= MemReadM;
    end else if (state == BUSY && dmem_ack) begin
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      if (lat_load) ReadDataM <= load_fmt;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] ReadDataM;
  logic        StallM, MisalignedM;

  int ncmp = 0;
  int nbad = 0;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .ReadDataM(ReadDataM), .StallM(StallM), .MisalignedM(MisalignedM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mr, mw;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rdata;
    int          ack_cyc;
    logic        legal, mis, we;
    logic [31:0] eaddr, ewdata;
    logic [3:0]  ebe;
    logic [31:0] erd;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic mr, logic mw, logic [2:0] f3,
                              logic [31:0] addr, logic [31:0] wd,
                              logic [31:0] rdata, int ack_cyc,
                              logic legal, logic mis, logic we,
                              logic [31:0] eaddr, logic [31:0] ewdata,
                              logic [3:0] ebe, logic [31:0] erd);
    vec_t v;
    v.mr = mr; v.mw = mw; v.f3 = f3; v.addr = addr; v.wd = wd;
    v.rdata = rdata; v.ack_cyc = ack_cyc; v.legal = legal; v.mis = mis;
    v.we = we; v.eaddr = eaddr; v.ewdata = ewdata; v.ebe = ebe; v.erd = erd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000;
    ALUResultM = '0; WriteDataM = '0; dmem_ack = 1'b0; dmem_rdata = '0;
  endtask

  // Entered and left #1 after a rising edge.
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    MemReadM = v.mr; MemWriteM = v.mw; Funct3M = v.f3;
    ALUResultM = v.addr; WriteDataM = v.wd; dmem_rdata = v.rdata;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk({tag, ".stall0"}, 32'(StallM), 32'(v.legal));
    chk({tag, ".mis"}, 32'(MisalignedM), 32'(v.mis));
    chk({tag, ".req0"}, 32'(dmem_req), 32'd0);
    if (v.legal) begin
      @(posedge clk); #1;
      for (int c = 1; c <= v.ack_cyc; c++) begin
        dmem_ack = (c == v.ack_cyc);
        @(negedge clk);
        chk($sformatf("%s.req_c%0d", tag, c), 32'(dmem_req), 32'd1);
        chk($sformatf("%s.stall_c%0d", tag, c), 32'(StallM), 32'd1);
        chk({tag, ".we"}, 32'(dmem_we), 32'(v.we));
        chk({tag, ".addr"}, dmem_addr, v.eaddr);
        chk({tag, ".wdata"}, dmem_wdata, v.ewdata);
        chk({tag, ".be"}, 32'(dmem_be), 32'(v.ebe));
        @(posedge clk); #1;
      end
      dmem_ack = 1'b0;
      @(negedge clk);
      chk({tag, ".done_req"}, 32'(dmem_req), 32'd0);
      chk({tag, ".done_stall"}, 32'(StallM), 32'd0);
      chk({tag, ".rd"}, ReadDataM, v.erd);
      @(posedge clk); #1;
    end else begin
      chk({tag, ".rd_hold0"}, ReadDataM, v.erd);
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, ".req1"}, 32'(dmem_req), 32'd0);
      chk({tag, ".stall1"}, 32'(StallM), 32'd0);
      chk({tag, ".mis1"}, 32'(MisalignedM), 32'(v.mis));
      chk({tag, ".rd_hold1"}, ReadDataM, v.erd);
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask

  initial begin
    //          mr   mw   f3      addr          wd            rdata         ack legal mis  we   eaddr         ewdata        be       erd
    vecs[0]  = mk(1'b1,1'b0,3'b010,32'h0000_0100,32'h0,       32'hDEAD_BEEF,3, 1'b1,1'b0,1'b0,32'h0000_0100,32'h0,       4'b1111,32'hDEAD_BEEF);
    vecs[1]  = mk(1'b1,1'b0,3'b000,32'h0000_0103,32'h0,       32'h8011_2233,1, 1'b1,1'b0,1'b0,32'h0000_0100,32'h0,       4'b1000,32'hFFFF_FF80);
    vecs[2]  = mk(1'b1,1'b0,3'b100,32'h0000_0103,32'h0,       32'h8011_2233,1, 1'b1,1'b0,1'b0,32'h0000_0100,32'h0,       4'b1000,32'h0000_0080);
    vecs[3]  = mk(1'b1,1'b0,3'b101,32'h0000_0102,32'h0,       32'h8011_2233,2, 1'b1,1'b0,1'b0,32'h0000_0100,32'h0,       4'b1100,32'h0000_8011);
    vecs[4]  = mk(1'b1,1'b0,3'b001,32'h0000_0100,32'h0,       32'h1234_F00D,1, 1'b1,1'b0,1'b0,32'h0000_0100,32'h0,       4'b0011,32'hFFFF_F00D);
    vecs[5]  = mk(1'b1,1'b0,3'b000,32'h0000_0100,32'h0,       32'h0000_007F,1, 1'b1,1'b0,1'b0,32'h0000_0100,32'h0,       4'b0001,32'h0000_007F);
    vecs[6]  = mk(1'b0,1'b1,3'b000,32'h0000_0201,32'h0000_00A5,32'h5555_5555,1,1'b1,1'b0,1'b1,32'h0000_0200,32'hA5A5_A5A5,4'b0010,32'h0000_007F);
    vecs[7]  = mk(1'b0,1'b1,3'b001,32'h0000_0202,32'h0000_BEEF,32'h5555_5555,2,1'b1,1'b0,1'b1,32'h0000_0200,32'hBEEF_BEEF,4'b1100,32'h0000_007F);
    vecs[8]  = mk(1'b0,1'b1,3'b010,32'h0000_0204,32'h1234_5678,32'h5555_5555,2,1'b1,1'b0,1'b1,32'h0000_0204,32'h1234_5678,4'b1111,32'h0000_007F);
    vecs[9]  = mk(1'b1,1'b0,3'b010,32'h0000_0102,32'h0,       32'h5555_5555,1, 1'b0,1'b1,1'b0,32'h0,       32'h0,       4'b0000,32'h0000_007F);
    vecs[10] = mk(1'b0,1'b1,3'b001,32'h0000_0101,32'h0000_1111,32'h5555_5555,1,1'b0,1'b1,1'b0,32'h0,       32'h0,       4'b0000,32'h0000_007F);
    vecs[11] = mk(1'b1,1'b0,3'b011,32'h0000_0100,32'h0,       32'h5555_5555,1, 1'b0,1'b1,1'b0,32'h0,       32'h0,       4'b0000,32'h0000_007F);
    vecs[12] = mk(1'b0,1'b1,3'b100,32'h0000_0100,32'h0000_0022,32'h5555_5555,1,1'b0,1'b1,1'b0,32'h0,       32'h0,       4'b0000,32'h0000_007F);
    vecs[13] = mk(1'b1,1'b1,3'b010,32'h0000_0100,32'h0,       32'h5555_5555,1, 1'b0,1'b1,1'b0,32'h0,       32'h0,       4'b0000,32'h0000_007F);
    vecs[14] = mk(1'b0,1'b0,3'b010,32'h0000_0100,32'h0,       32'h5555_5555,1, 1'b0,1'b0,1'b0,32'h0,       32'h0,       4'b0000,32'h0000_007F);
    vecs[15] = mk(1'b1,1'b0,3'b100,32'h0000_0101,32'h0,       32'h0000_AB00,1, 1'b1,1'b0,1'b0,32'h0000_0100,32'h0,       4'b0010,32'h0000_00AB);

    // Reset with a legal load presented: everything low, including StallM.
    rst_n = 1'b0;
    clear_inputs();
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h0000_0100;
    #3;
    chk("rst.req", 32'(dmem_req), 32'd0);
    chk("rst.we", 32'(dmem_we), 32'd0);
    chk("rst.addr", dmem_addr, 32'd0);
    chk("rst.wdata", dmem_wdata, 32'd0);
    chk("rst.be", 32'(dmem_be), 32'd0);
    chk("rst.rd", ReadDataM, 32'd0);
    chk("rst.stall", 32'(StallM), 32'd0);
    @(posedge clk); #1;
    chk("rst.req_after_edge", 32'(dmem_req), 32'd0);
    clear_inputs();
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Ack while idle is ignored.
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("idle_ack.req", 32'(dmem_req), 32'd0);
      chk("idle_ack.stall", 32'(StallM), 32'd0);
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack.rd", ReadDataM, 32'h0000_00AB);
    @(posedge clk); #1;

    // Reset while BUSY, then a late ack after release.
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h0000_0100;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rbusy.req_before", 32'(dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rbusy.req", 32'(dmem_req), 32'd0);
    chk("rbusy.stall", 32'(StallM), 32'd0);
    chk("rbusy.rd", ReadDataM, 32'd0);
    chk("rbusy.addr", dmem_addr, 32'd0);
    clear_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("rbusy.late_req", 32'(dmem_req), 32'd0);
    chk("rbusy.late_stall", 32'(StallM), 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("rbusy.late_rd", ReadDataM, 32'd0);
    chk("rbusy.late_req2", 32'(dmem_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
